// File: rtl/minute_hour_counter.sv
// Minutes/hours BCD time-of-day counter with a RUN/SET FSM, synchronised and debounced set buttons.
// Supports 24-hour display or 12-hour display with a PM flag.
module minute_hour_counter #(
   parameter int MODE_24H        = 1,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clock_sig,
   input  logic       reset_sig,
   input  logic       sec_wrap_sig,
   input  logic       set_mode_sig,
   input  logic       inc_min_sig,
   input  logic       inc_hour_sig,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic [3:0] hour_ones,
   output logic [3:0] hour_tens,
   output logic       pm_sig,
   output logic       day_wrap_sig,
   output logic       set_active_sig
);

   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    HT_RST  = (MODE_24H != 0) ? 4'd0 : 4'd1;
   localparam logic [3:0]    HO_RST  = (MODE_24H != 0) ? 4'd0 : 4'd2;

   typedef enum logic {RUN, SET} state_t;

   state_t        state;
   logic [2:0]    meta;
   logic [2:0]    sync;          // {inc_hour, inc_min, set_mode}
   logic [1:0]    btn;
   logic [1:0]    db;
   logic [1:0]    strobe;
   logic [CW-1:0] cnt [2];
   logic          run;
   logic          min_max;
   logic          min_adv;
   logic          hour_adv;
   logic          day_end;
   logic          pm_next;
   logic [3:0]    hr_tens_next;
   logic [3:0]    hr_ones_next;

   always_ff @(posedge clock_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {inc_hour_sig, inc_min_sig, set_mode_sig};
         sync <= meta;
      end
   end

   assign btn = sync[2:1];

   // The strobe fires on the same edge the debounced level rises, so it lasts exactly one cycle.
   always_ff @(posedge clock_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         db     <= '0;
         strobe <= '0;
         for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            strobe[i] <= 1'b0;
            if (btn[i] != db[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  db[i]     <= btn[i];
                  cnt[i]    <= '0;
                  strobe[i] <= btn[i];
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clock_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         state          <= RUN;
         set_active_sig <= 1'b0;
      end else begin
         state          <= sync[0] ? SET : RUN;
         set_active_sig <= sync[0];
      end
   end

   assign run      = (state == RUN);
   assign min_max  = (min_tens == 4'd5) && (min_ones == 4'd9);
   assign min_adv  = run ? sec_wrap_sig : strobe[0];
   assign hour_adv = run ? (min_adv & min_max) : strobe[1];

   always_comb begin
      hr_tens_next = hour_tens;
      hr_ones_next = hour_ones + 4'd1;
      pm_next      = pm_sig;
      day_end      = 1'b0;
      if (MODE_24H != 0) begin
         if (hour_tens == 4'd2 && hour_ones == 4'd3) begin
            hr_tens_next = '0;
            hr_ones_next = '0;
            day_end      = 1'b1;
         end else if (hour_ones == 4'd9) begin
            hr_tens_next = hour_tens + 4'd1;
            hr_ones_next = '0;
         end
      end else begin
         if (hour_tens == 4'd1 && hour_ones == 4'd2) begin
            hr_tens_next = 4'd0;
            hr_ones_next = 4'd1;
         end else if (hour_tens == 4'd1 && hour_ones == 4'd1) begin
            hr_tens_next = 4'd1;
            hr_ones_next = 4'd2;
            pm_next      = ~pm_sig;
            day_end      = pm_sig;
         end else if (hour_ones == 4'd9) begin
            hr_tens_next = 4'd1;
            hr_ones_next = '0;
         end
      end
   end

   always_ff @(posedge clock_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         min_ones     <= '0;
         min_tens     <= '0;
         hour_ones    <= HO_RST;
         hour_tens    <= HT_RST;
         pm_sig       <= 1'b0;
         day_wrap_sig <= 1'b0;
      end else begin
         if (min_adv) begin
            if (min_ones == 4'd9) begin
               min_ones <= '0;
               min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
            end else begin
               min_ones <= min_ones + 4'd1;
            end
         end
         if (hour_adv) begin
            hour_tens <= hr_tens_next;
            hour_ones <= hr_ones_next;
            pm_sig    <= pm_next;
         end
         day_wrap_sig <= run & hour_adv & day_end;
      end
   end

endmodule

// File: tb/tb_minute_hour_counter.sv
// Bench for minute_hour_counter: a 24h and a 12h instance share stimulus and are
// checked every cycle against a minutes/hours-of-day model plus literal expectations.
module tb_minute_hour_counter;

   logic clock_sig    = 1'b0;
   logic reset_sig    = 1'b0;
   logic sec_wrap_sig = 1'b0;
   logic set_mode_sig = 1'b0;
   logic inc_min_sig  = 1'b0;
   logic inc_hour_sig = 1'b0;

   logic [3:0] a_mo, a_mt, a_ho, a_ht;
   logic       a_pm, a_dw, a_sa;
   logic [3:0] b_mo, b_mt, b_ho, b_ht;
   logic       b_pm, b_dw, b_sa;

   int checks = 0;
   int errors = 0;

   minute_hour_counter #(.MODE_24H(1), .DEBOUNCE_CYCLES(4)) dut24 (
      .clock_sig(clock_sig), .reset_sig(reset_sig), .sec_wrap_sig(sec_wrap_sig),
      .set_mode_sig(set_mode_sig), .inc_min_sig(inc_min_sig), .inc_hour_sig(inc_hour_sig),
      .min_ones(a_mo), .min_tens(a_mt), .hour_ones(a_ho), .hour_tens(a_ht),
      .pm_sig(a_pm), .day_wrap_sig(a_dw), .set_active_sig(a_sa)
   );

   minute_hour_counter #(.MODE_24H(0), .DEBOUNCE_CYCLES(4)) dut12 (
      .clock_sig(clock_sig), .reset_sig(reset_sig), .sec_wrap_sig(sec_wrap_sig),
      .set_mode_sig(set_mode_sig), .inc_min_sig(inc_min_sig), .inc_hour_sig(inc_hour_sig),
      .min_ones(b_mo), .min_tens(b_mt), .hour_ones(b_ho), .hour_tens(b_ht),
      .pm_sig(b_pm), .day_wrap_sig(b_dw), .set_active_sig(b_sa)
   );

   always #5 clock_sig = ~clock_sig;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time of day as plain integers; raw input histories give the
   // 2-cycle synchroniser delay and the "4 consecutive samples" debounce rule.
   int         m_min = 0;
   int         m_hr  = 0;
   bit         m_dw  = 0;
   bit         m_sa  = 0;
   logic [5:0] hs = '0, hm = '0, hh = '0;
   bit         db_m = 0, db_h = 0, ev_m = 0, ev_h = 0;

   always @(posedge clock_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         m_min = 0; m_hr = 0; m_dw = 0; m_sa = 0;
         hs = '0; hm = '0; hh = '0;
         db_m = 0; db_h = 0; ev_m = 0; ev_h = 0;
      end else begin : upd
         bit run, madv, hadv;
         hs = {hs[4:0], set_mode_sig};
         hm = {hm[4:0], inc_min_sig};
         hh = {hh[4:0], inc_hour_sig};
         run  = !hs[3];
         madv = run ? sec_wrap_sig : ev_m;
         hadv = run ? (madv && m_min == 59) : ev_h;
         m_dw = run && hadv && m_hr == 23;
         if (madv) m_min = (m_min + 1) % 60;
         if (hadv) m_hr = (m_hr + 1) % 24;
         m_sa = hs[2];
         ev_m = !db_m && (hm[5:2] == 4'b1111);
         ev_h = !db_h && (hh[5:2] == 4'b1111);
         if (hm[5:2] == {4{~db_m}}) db_m = ~db_m;
         if (hh[5:2] == {4{~db_h}}) db_h = ~db_h;
      end
   end

   always @(negedge clock_sig) begin : cmp
      int h12;
      h12 = (m_hr % 12 == 0) ? 12 : m_hr % 12;
      chk("min_ones24",  a_mo, m_min % 10);
      chk("min_tens24",  a_mt, m_min / 10);
      chk("hour_ones24", a_ho, m_hr % 10);
      chk("hour_tens24", a_ht, m_hr / 10);
      chk("pm24",        a_pm, 0);
      chk("day_wrap24",  a_dw, m_dw);
      chk("set_active24", a_sa, m_sa);
      chk("min_ones12",  b_mo, m_min % 10);
      chk("min_tens12",  b_mt, m_min / 10);
      chk("hour_ones12", b_ho, h12 % 10);
      chk("hour_tens12", b_ht, h12 / 10);
      chk("pm12",        b_pm, (m_hr >= 12) ? 1 : 0);
      chk("day_wrap12",  b_dw, m_dw);
      chk("set_active12", b_sa, m_sa);
   end

   task automatic pulse_sec();
      @(negedge clock_sig) sec_wrap_sig = 1'b1;
      @(negedge clock_sig) sec_wrap_sig = 1'b0;
   endtask

   task automatic press(input logic m, input logic h);
      @(negedge clock_sig);
      inc_min_sig  = m;
      inc_hour_sig = h;
      repeat (6) @(negedge clock_sig);
      inc_min_sig  = 1'b0;
      inc_hour_sig = 1'b0;
      repeat (8) @(negedge clock_sig);
   endtask

   task automatic bounce_min();
      logic [21:0] pat;
      pat = 22'b1110001110001111111111;
      for (int i = 21; i >= 0; i--) begin
         @(negedge clock_sig) inc_min_sig = pat[i];
      end
      @(negedge clock_sig) inc_min_sig = 1'b0;
      repeat (8) @(negedge clock_sig);
   endtask

   task automatic set_mode(input logic v);
      @(negedge clock_sig) set_mode_sig = v;
      repeat (5) @(negedge clock_sig);
   endtask

   function automatic int t24();
      return int'({a_ht, a_ho, a_mt, a_mo});
   endfunction

   function automatic int t12();
      return int'({b_pm, b_ht, b_ho, b_mt, b_mo});
   endfunction

   initial begin
      repeat (3) @(negedge clock_sig);
      chk("reset_24", t24(), 'h0000);
      chk("reset_12", t12(), 'h01200);
      reset_sig = 1'b1;

      for (int i = 0; i < 59; i++) pulse_sec();
      chk("run_59min", t24(), 'h0059);
      pulse_sec();
      chk("run_60th_carry", t24(), 'h0100);

      set_mode(1'b1);
      chk("set_active_on", a_sa, 1);
      for (int i = 0; i < 22; i++) press(1'b0, 1'b1);
      for (int i = 0; i < 58; i++) press(1'b1, 1'b0);
      chk("preset_2358", t24(), 'h2358);
      bounce_min();
      chk("bounce_one_inc", t24(), 'h2359);
      press(1'b1, 1'b0);
      chk("set_min_wrap_no_carry", t24(), 'h2300);
      for (int i = 0; i < 59; i++) press(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) pulse_sec();
      chk("set_ignores_sec", t24(), 'h2359);
      chk("preset_1159pm", t12(), 'h11159);
      set_mode(1'b0);
      pulse_sec();
      chk("day_wrap_24", t24(), 'h0000);
      chk("day_wrap_pulse", a_dw, 1);
      chk("midnight_12", t12(), 'h01200);
      chk("day_wrap_pulse12", b_dw, 1);
      @(negedge clock_sig);
      chk("day_wrap_one_cycle", a_dw, 0);

      set_mode(1'b1);
      @(negedge clock_sig);
      inc_min_sig  = 1'b1;
      inc_hour_sig = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clock_sig) sec_wrap_sig = ~sec_wrap_sig;
      sec_wrap_sig = 1'b0;
      inc_min_sig  = 1'b0;
      inc_hour_sig = 1'b0;
      repeat (8) @(negedge clock_sig);
      chk("both_events", t24(), 'h0101);
      for (int i = 0; i < 10; i++) press(1'b0, 1'b1);
      for (int i = 0; i < 58; i++) press(1'b1, 1'b0);
      chk("preset_1159am", t12(), 'h01159);
      set_mode(1'b0);
      pulse_sec();
      chk("noon_12", t12(), 'h11200);
      chk("noon_24", t24(), 'h1200);
      chk("noon_no_day_wrap", b_dw, 0);

      for (int i = 0; i < 157; i++) pulse_sec();
      chk("at_1437", t24(), 'h1437);
      chk("at_0237pm", t12(), 'h10237);
      set_mode_sig = 1'b1;
      inc_min_sig  = 1'b1;
      repeat (4) @(negedge clock_sig);
      #2 reset_sig = 1'b0;
      #1;
      chk("async_reset_24", t24(), 'h0000);
      chk("async_reset_12", t12(), 'h01200);
      chk("async_reset_set_active", a_sa, 0);
      repeat (3) @(negedge clock_sig);
      set_mode_sig = 1'b0;
      inc_min_sig  = 1'b0;
      reset_sig    = 1'b1;
      repeat (20) @(negedge clock_sig);
      chk("pending_event_dropped", t24(), 'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
